// File: rtl/sram_1r1w_be.sv
// Simple dual-port byte-strobed SRAM bank with configurable read latency,
// optional same-address write bypass and a zero-fill sweep engine.
module sram_1r1w_be #(
    parameter int BYTES_SIZE     = 8,
    parameter int BYTES_CNT      = 4,
    parameter int WORD_SIZE      = BYTES_SIZE * BYTES_CNT,
    parameter int WORD_ADDR_BITS = 14,
    parameter int WORD_CNT       = 1 << WORD_ADDR_BITS,
    parameter int READ_LAT       = 1,
    parameter int BYPASS         = 1,
    parameter int INIT_ON_RST    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    output logic                      busy,
    input  logic                      rd_en,
    input  logic [WORD_ADDR_BITS-1:0] rd_addr,
    output logic [WORD_SIZE-1:0]      rd_data,
    output logic                      rd_valid,
    input  logic [BYTES_CNT-1:0]      wr_en,
    input  logic [WORD_ADDR_BITS-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]      wr_data
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                      state, state_nxt;
    logic [WORD_ADDR_BITS-1:0]   cnt, cnt_nxt;
    logic                        init_pend;
    logic                        port_open;
    logic                        rd_acc;

    // init_pend turns the first post-reset edge into a sweep start when enabled
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        port_open = 1'b0;
        case (state)
            IDLE: begin
                if (clr || init_pend) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end else begin
                    port_open = 1'b1;
                end
            end
            SWEEP: begin
                cnt_nxt = cnt + 1'b1;
                if (&cnt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            init_pend <= 1'(INIT_ON_RST != 0);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_pend <= 1'b0;
        end
    end

    assign busy   = (state == SWEEP);
    assign rd_acc = port_open & rd_en;

    // Write port is shared between the user and the sweep engine
    logic [BYTES_CNT-1:0]                 lane_we;
    logic [WORD_ADDR_BITS-1:0]            wa;
    logic [BYTES_CNT-1:0][BYTES_SIZE-1:0] wd_l;
    logic [BYTES_CNT-1:0][BYTES_SIZE-1:0] wr_l;
    logic [BYTES_CNT-1:0][BYTES_SIZE-1:0] rd_l;
    logic                                 same_addr;

    assign lane_we   = busy ? '1 : (port_open ? wr_en : '0);
    assign wa        = busy ? cnt : wr_addr;
    assign wr_l      = wr_data;
    assign wd_l      = busy ? '0 : wr_l;
    assign same_addr = (BYPASS != 0) && port_open && (wr_addr == rd_addr);

    for (genvar g = 0; g < BYTES_CNT; g++) begin : g_lane
        logic [BYTES_SIZE-1:0] bank [WORD_CNT];

        always_ff @(posedge clk) begin
            if (lane_we[g]) bank[wa] <= wd_l[g];
        end

        assign rd_l[g] = (same_addr && wr_en[g]) ? wr_l[g] : bank[rd_addr];
    end

    // Read pipeline; data stages only load on a valid so rd_data holds between results
    logic [READ_LAT:1]  vld_pipe;
    logic [WORD_SIZE-1:0] dat_pipe [1:READ_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= READ_LAT; s++) dat_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) dat_pipe[1] <= rd_l;
            for (int s = 2; s <= READ_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rd_valid = vld_pipe[READ_LAT];
    assign rd_data  = dat_pipe[READ_LAT];

endmodule
